// File: rtl/tt_input_pkg.sv
// Shared constants and helpers for the input conditioning stages.
// Holds the default button count, synchroniser depth and debounce length.
package tt_input_pkg;

    localparam int DEF_BUTTON_WIDTH    = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;

    // Wide enough to hold 0 .. n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_debounce_sync_if.sv
// Button bus between the pads and the debounce stage.
// Carries the enable and raw pins in, and the conditioned levels and pulses out.
interface button_debounce_sync_if #(
    parameter int WIDTH = 4
);

    logic             ena;
    logic [WIDTH-1:0] raw_n;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any_change;

    modport master (
        output ena,
        output raw_n,
        input  level,
        input  rise,
        input  fall,
        input  any_change
    );

    modport slave (
        input  ena,
        input  raw_n,
        output level,
        output rise,
        output fall,
        output any_change
    );

endinterface

// File: rtl/debounce_bit.sv
// Single-button conditioner: synchroniser, debounce counter, level and edge pulses.
// The raw pin is active-low; level/rise/fall are active-high.
module debounce_bit
    import tt_input_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena_i,
    input  logic raw_n_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sample;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_n_i};
    assign sample = ~sync_q[SYNC_STAGES-1];

    // Level flips only after DEBOUNCE_CYCLES enabled cycles of disagreement.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (ena_i) begin
            if (sample == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                cnt_d   = '0;
                level_d = sample;
                rise_d  = sample;
                fall_d  = ~sample;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/button_debounce_sync.sv
// Conditions the four active-low push-buttons into clean levels and pulses.
// Each bit is handled by an independent debounce_bit instance.
module button_debounce_sync
    import tt_input_pkg::*;
#(
    parameter int WIDTH           = DEF_BUTTON_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    button_debounce_sync_if.slave bus
);

    logic [WIDTH-1:0] level_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena_i   (bus.ena),
            .raw_n_i (bus.raw_n[i]),
            .level_o (level_w[i]),
            .rise_o  (rise_w[i]),
            .fall_o  (fall_w[i])
        );
    end

    assign bus.level      = level_w;
    assign bus.rise       = rise_w;
    assign bus.fall       = fall_w;
    assign bus.any_change = |(rise_w | fall_w);

endmodule

// File: tb/tb_button_debounce_sync.sv
// Directed bench for button_debounce_sync with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Expected values are hand-derived edge counts from the point each input changes.
module tb_button_debounce_sync;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    button_debounce_sync_if #(.WIDTH(4)) bus ();

    button_debounce_sync #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_level"}, 8'(bus.level), 8'h0);
        chk({tag, "_rise"}, 8'(bus.rise), 8'h0);
        chk({tag, "_fall"}, 8'(bus.fall), 8'h0);
        chk({tag, "_any"}, 8'(bus.any_change), 8'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n     = 1'b0;
        bus.ena   = 1'b1;
        bus.raw_n = 4'hF;

        // reset values
        step();
        step();
        chk_idle("rst_during");
        rst_n = 1'b1;
        step();
        step();
        chk_idle("rst_after");

        // clean press on bit 0
        bus.raw_n = 4'hE;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("press_lvl_e%0d", k), 8'(bus.level[0]), 8'(k >= 6));
            chk($sformatf("press_rise_e%0d", k), 8'(bus.rise[0]), 8'(k == 6));
            chk($sformatf("press_any_e%0d", k), 8'(bus.any_change), 8'(k == 6));
        end
        step();
        chk("press_rise_drop", 8'(bus.rise), 8'h0);
        chk("press_lvl_hold", 8'(bus.level), 8'h1);

        // clean release on bit 0
        bus.raw_n = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("rel_lvl_e%0d", k), 8'(bus.level[0]), 8'(k < 6));
            chk($sformatf("rel_fall_e%0d", k), 8'(bus.fall[0]), 8'(k == 6));
            chk($sformatf("rel_rise_e%0d", k), 8'(bus.rise), 8'h0);
        end
        step();
        chk("rel_fall_drop", 8'(bus.fall), 8'h0);
        chk("rel_any_drop", 8'(bus.any_change), 8'h0);

        // bounce: three cycles low is one short of the debounce length
        bus.raw_n = 4'hD;
        step();
        step();
        step();
        bus.raw_n = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("bounce_lvl_e%0d", k), 8'(bus.level), 8'h0);
            chk($sformatf("bounce_any_e%0d", k), 8'(bus.any_change), 8'h0);
        end

        // 0,1 glitch then held low: one rise, 6 edges after the final low
        bus.raw_n = 4'hD;
        step();
        chk("glitch_a", 8'(bus.rise), 8'h0);
        bus.raw_n = 4'hF;
        step();
        chk("glitch_b", 8'(bus.rise), 8'h0);
        bus.raw_n = 4'hD;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("glitch_lvl_e%0d", k), 8'(bus.level), 8'(k >= 6 ? 2 : 0));
            chk($sformatf("glitch_rise_e%0d", k), 8'(bus.rise), 8'(k == 6 ? 2 : 0));
        end
        bus.raw_n = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("glitch_fall_e%0d", k), 8'(bus.fall), 8'(k == 6 ? 2 : 0));
        end
        chk("glitch_lvl_end", 8'(bus.level), 8'h0);

        // bits 3:2 together with a 2-cycle enable gap mid-count
        bus.raw_n = 4'h3;
        for (int k = 1; k <= 8; k++) begin
            bus.ena = (k == 4 || k == 5) ? 1'b0 : 1'b1;
            step();
            chk($sformatf("gap_lvl_e%0d", k), 8'(bus.level), 8'(k >= 8 ? 4'hC : 4'h0));
            chk($sformatf("gap_rise_e%0d", k), 8'(bus.rise), 8'(k == 8 ? 4'hC : 4'h0));
            chk($sformatf("gap_any_e%0d", k), 8'(bus.any_change), 8'(k == 8));
        end
        bus.ena   = 1'b1;
        bus.raw_n = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("gap_fall_e%0d", k), 8'(bus.fall), 8'(k == 6 ? 4'hC : 4'h0));
        end
        chk("gap_lvl_end", 8'(bus.level), 8'h0);

        // reset mid-count discards the partial count
        bus.raw_n = 4'hE;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("midrst_pre_e%0d", k), 8'(bus.rise), 8'h0);
        end
        rst_n = 1'b0;
        step();
        chk_idle("midrst_in");
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("midrst_rise_e%0d", k), 8'(bus.rise), 8'(k == 6));
            chk($sformatf("midrst_lvl_e%0d", k), 8'(bus.level), 8'(k >= 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_debounce_sync.md
# button_debounce_sync

Input conditioning stage for the four active-low push-buttons on `ui_in[3:0]`. It sits directly upstream of the nibble inverter stage and replaces its raw feed. Each input is synchronised, debounced and inverted, so the block delivers clean active-high levels plus one-cycle press and release pulses. `ui_in[7:4]` is not touched and continues to pass straight through at top level.

## Interface
Parameters:
- `WIDTH`, 4: number of button inputs.
- `SYNC_STAGES`, 2: synchroniser flop depth; must be ≥ 2.
- `DEBOUNCE_CYCLES`, 50000: consecutive enabled cycles of disagreement needed before the level flips; must be ≥ 1.

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- `clk`  input  1  system clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `ena`  input  1  design enable; low freezes debounce state.
- `raw_n`  input  WIDTH  raw active-low button pins (`ui_in[3:0]`).
- `level`  output  WIDTH  debounced active-high level (1 = pressed).
- `rise`  output  WIDTH  one-cycle pulse on the debounced press.
- `fall`  output  WIDTH  one-cycle pulse on the debounced release.
- `any_change`  output  1  OR of `rise | fall`, same cycle.

## Operation
- **Sync chain:** `SYNC_STAGES` flops per bit.
  - Resets to all-ones (released).
  - Always clocks, independent of `ena`.
  - `sample[i]` = inverted last sync stage.
- **Per-bit counter:** `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES+1)`. Updates only when `ena` = 1:
  - `sample == level`: `cnt` clears to 0.
  - `sample != level` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` increments.
  - `sample != level` and `cnt == DEBOUNCE_CYCLES-1`: `level` toggles and `cnt` clears. Toggle 0→1 sets `rise`; toggle 1→0 sets `fall`.
- **Counter bound:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`. No wrap-around is possible.
- **`rise` / `fall`:** registered. High exactly for the first cycle `level` shows its new value, then 0. Never high together for the same bit.
- **`ena` = 0:**
  - `cnt` and `level` hold.
  - `rise`, `fall` and `any_change` are forced to 0 on the next edge.
- **Bit independence:** bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses.
- **Reset:** all outputs are 0 after reset (`level` = 0, `rise` = 0, `fall` = 0, `any_change` = 0). Counters are 0 and sync flops are 1.
  - Reset asserted mid-count discards the partial count.
  - A button held through reset is detected as a fresh press after the full latency.

## Timing
- **Latency:** `level` changes on the (`SYNC_STAGES` + `DEBOUNCE_CYCLES`)-th rising edge of `clk`. Edge 1 is the first edge that samples the new `raw_n` value. This assumes `ena` = 1 throughout and a stable input.
- **Glitch rejection:** any `sample` disagreement lasting fewer than `DEBOUNCE_CYCLES` enabled cycles resets the count and produces no output change.
- **`DEBOUNCE_CYCLES` = 1:** `level` follows `sample` with one extra edge.
- **Enable gaps:** cycles with `ena` = 0 extend the latency one-for-one.
- **Output timing:** all outputs are flop outputs; there is no combinational path from inputs to outputs.

## Structure
- **Shared package `tt_input_pkg`:** holds the default constants (`DEF_SYNC_STAGES`, `DEF_DEBOUNCE_CYCLES`, `DEF_BUTTON_WIDTH`) and a `cnt_width(n)` function.
- **Sub-module `debounce_bit`:** one natural sub-module covering the sync chain, counter, level, rise and fall for a single bit. It is instanced `WIDTH` times in a generate loop.
- **Top wrapper:** the top level only ORs the pulses into `any_change`.

## Test plan
Run with `SYNC_STAGES` = 2 and `DEBOUNCE_CYCLES` = 4 unless stated otherwise.
- **Reset values:** assert `rst_n` = 0 with `raw_n` = 4'hF -> `level` = 0, `rise` = 0, `fall` = 0 and `any_change` = 0 during reset and after release.
- **Clean press:** drive `raw_n[0]` to 0 and hold -> `level[0]` = 1 on the 6th edge, `rise[0]` = 1 for exactly that cycle and `any_change` = 1 in the same cycle.
- **Clean release:** release `raw_n[0]` to 1 -> `level[0]` = 0 on the 6th edge and `fall[0]` = 1 for one cycle.
- **Bounce rejection:** drive `raw_n[1]` = 0 for 3 cycles, then 1 -> `level[1]` stays 0 and no pulse occurs. Then drive it 0,1,0,0,0,0,0 -> exactly one `rise[1]`, on the 6th edge after the final low.
- **Enable gap and simultaneous bits:** press `raw_n[3:2]` together with `ena` dropped for 2 cycles mid-count -> `level[3:2]` = 2'b11 on the same edge, 8 edges after the press, with simultaneous `rise[3:2]`.
- **Reset mid-count:** hold `raw_n[0]` low, assert `rst_n` after 4 edges, release it and keep holding -> no pulse before reset; `rise[0]` fires 6 edges after reset release.
